// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared mdOp encodings, FSM states and result helper for the MDU
package mdu_pkg;

  typedef enum logic [2:0] {
    NOT_MD = 3'd0,
    MULT   = 3'd1,
    MULTU  = 3'd2,
    DIV    = 3'd3,
    DIVU   = 3'd4,
    MTHI   = 3'd5,
    MTLO   = 3'd6
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic        wr;
    logic [63:0] res;
  } md_result_t;

  function automatic logic md_is_launch(input logic [2:0] op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  // Signed division works on magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // without relying on simulator overflow behaviour.
  function automatic md_result_t md_compute(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    md_result_t r;
    logic [31:0] ua, ub, q, m;
    r  = '0;
    ua = a;
    ub = b;
    q  = '0;
    m  = '0;
    if (op == DIV) begin
      ua = a[31] ? -a : a;
      ub = b[31] ? -b : b;
    end
    case (op)
      MULT: begin
        r.wr  = 1'b1;
        r.res = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      end
      MULTU: begin
        r.wr  = 1'b1;
        r.res = {32'b0, a} * {32'b0, b};
      end
      DIV, DIVU: begin
        if (b != 32'd0) begin
          q = ua / ub;
          m = ua % ub;
          if (op == DIV) begin
            if (a[31] ^ b[31]) q = -q;
            if (a[31]) m = -m;
          end
          r.wr  = 1'b1;
          r.res = {m, q};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit owning the HI/LO registers
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  mdOp,
  input  logic        start,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  md_state_e   r_state;
  md_state_e   w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [63:0] r_pres;
  logic        r_pwr;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        w_launch;
  logic        w_commit;
  md_result_t  w_res;

  assign w_res = md_compute(mdOp, srcA, srcB);
  assign busy  = (r_state == MD_BUSY);
  assign hi    = r_hi;
  assign lo    = r_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MD_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (start && md_is_launch(mdOp)) begin
          w_launch    = 1'b1;
          w_state_nxt = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (r_cnt <= CW'(1)) begin
          w_commit    = 1'b1;
          w_state_nxt = MD_IDLE;
        end
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  // Divide-by-zero launches with r_pwr clear, so the commit leaves HI/LO alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_pres <= '0;
      r_pwr  <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      if (w_launch) begin
        r_cnt  <= ((mdOp == MULT) || (mdOp == MULTU)) ? MULT_LOAD : DIV_LOAD;
        r_pres <= w_res.res;
        r_pwr  <= w_res.wr;
      end else if (r_state == MD_BUSY) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_commit && r_pwr) begin
        r_hi <= r_pres[63:32];
        r_lo <= r_pres[31:0];
      end
      if (r_state == MD_IDLE && mdOp == MTHI) r_hi <= srcA;
      if (r_state == MD_IDLE && mdOp == MTLO) r_lo <= srcA;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - scoreboard bench for the MDU commit values and busy duration
module tb_mdu;
  import mdu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [2:0]  mdOp;
  logic        start;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          dur;
  } exp_t;

  exp_t sb[$];

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mdOp  (mdOp),
    .start (start),
    .srcA  (srcA),
    .srcB  (srcB),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l, input int d);
    exp_t e;
    e.hi  = h;
    e.lo  = l;
    e.dur = d;
    sb.push_back(e);
  endtask

  // Called at a negedge; holds the inputs for one cycle.
  task automatic issue(input logic [2:0] op, input logic st, input logic [31:0] a, input logic [31:0] b);
    mdOp  = op;
    start = st;
    srcA  = a;
    srcB  = b;
    @(negedge clk);
    mdOp  = NOT_MD;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  initial begin
    logic prev_busy;
    int   bcnt;
    exp_t e;
    prev_busy = 1'b0;
    bcnt      = 0;
    forever begin
      @(negedge clk);
      if (busy) begin
        bcnt++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_commit: got hi=0x%08h lo=0x%08h expected no operation", hi, lo);
        end else begin
          e = sb.pop_front();
          chk("commit_hi", hi, e.hi);
          chk("commit_lo", lo, e.lo);
          if (e.dur != 0) chk("busy_cycles", 32'(bcnt), 32'(e.dur));
        end
        bcnt = 0;
      end
      prev_busy = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    mdOp     = NOT_MD;
    start    = 1'b0;
    srcA     = '0;
    srcB     = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);

    push(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    issue(MULT, 1'b1, 32'hFFFF_FFFE, 32'd3);
    wait_idle();

    push(32'h0000_0001, 32'hFFFF_FFFE, 5);
    issue(MULTU, 1'b1, 32'hFFFF_FFFF, 32'd2);
    wait_idle();
    push(32'd1, 32'd3, 10);
    issue(DIVU, 1'b1, 32'd7, 32'd2);
    wait_idle();

    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    push(32'h0, 32'h8000_0000, 10);
    issue(DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();

    issue(MTHI, 1'b0, 32'h12, 32'h0);
    chk("mthi", hi, 32'h12);
    issue(MTLO, 1'b0, 32'h34, 32'h0);
    chk("mtlo", lo, 32'h34);
    push(32'h12, 32'h34, 10);
    issue(DIV, 1'b1, 32'd5, 32'd0);
    wait_idle();

    push(32'd2, 32'd14, 10);
    issue(DIV, 1'b1, 32'd100, 32'd7);
    @(negedge clk);
    issue(MULT, 1'b1, 32'd5, 32'd5);
    issue(MTHI, 1'b0, 32'hAA, 32'h0);
    wait_idle();

    push(32'h0, 32'h0, 0);
    issue(MULTU, 1'b1, 32'd3, 32'd5);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
